mkio_msg_buf: RTL and testbench
===============================

Name: mkio_msg_buf

Overview:
- Multi-channel, double-buffered message RAM for MKIO subaddress data.
- The protocol engine writes one message at a time into the inactive bank of a channel, then commits it atomically.
- The host/readout side always reads the last committed message, with 1-cycle latency.
- Parametrised successor of the per-device RAMs: generalised channel count and depth, plus ping-pong banking, word counts and new-message flags.

Parameters:
- DATA_WIDTH, 16, word width.
- ADDR_WIDTH, 5, word address width; each bank holds 2**ADDR_WIDTH words.
- CH_WIDTH, 2, channel select width; CHANNELS = 2**CH_WIDTH.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- wr_ch  in  CH_WIDTH  target channel; sampled on wr_start only.
- wr_start  in  1  opens a message on wr_ch; clears the write pointer and wr_ovf.
- wr_en  in  1  writes wr_data at the current pointer; pointer increments.
- wr_data  in  DATA_WIDTH  write word.
- wr_commit  in  1  publishes the open message.
- wr_abort  in  1  discards the open message.
- wr_busy  out  1  a message is open.
- wr_ovf  out  1  sticky: a word was dropped because the bank was full.
- rd_ch  in  CH_WIDTH  read channel.
- rd_addr  in  ADDR_WIDTH  read word address.
- rd_en  in  1  read request.
- rd_ack  in  1  clears msg_new[rd_ch].
- q  out  DATA_WIDTH  read data.
- q_valid  out  1  q valid, 1 cycle after rd_en.
- rd_wcnt  out  ADDR_WIDTH+1  committed word count of the channel read; registered together with q.
- msg_new  out  CHANNELS  per-channel flag: an unread commit is present.

Behaviour:
- Storage: one inferred simple dual-port RAM (1 write, 1 read port) of CHANNELS*2*2**ADDR_WIDTH words, addressed {ch, bank, addr}. RAM contents are not reset.
- Per-channel registers:
  - bank_sel: committed bank.
  - wcnt: ADDR_WIDTH+1 bits.
  - msg_new bit.
- Reset values: all bank_sel=0, wcnt=0, msg_new=0, wr_busy=0, wr_ovf=0, q=0, q_valid=0, rd_wcnt=0; write pointer 0.
- Write FSM, states IDLE and OPEN:
  - IDLE --wr_start--> OPEN: latch wr_ch, ptr=0, wr_ovf=0.
  - OPEN --wr_commit--> IDLE: bank_sel[ch] toggles, wcnt[ch]=ptr (including any word written the same cycle), msg_new[ch]=1.
  - OPEN --wr_abort--> IDLE: no channel state changes.
  - OPEN --wr_start--> OPEN: the current message is discarded silently and a new one opens on the newly sampled wr_ch.
- Write data path:
  - wr_en in OPEN writes to the RAM at {ch, ~bank_sel[ch], ptr[ADDR_WIDTH-1:0]}; ptr then increments.
  - wr_en, wr_commit and wr_abort are ignored in IDLE.
  - Full bank: ptr == 2**ADDR_WIDTH with wr_en drops the word, does not write, and sets wr_ovf.
  - A commit while wr_ovf=1 behaves as abort; wr_ovf stays set until the next wr_start.
- Priority in one cycle: wr_abort > wr_commit. wr_start with wr_commit or wr_abort: start wins; the old message is discarded.
- A zero-length commit is legal: wcnt=0, bank toggles, msg_new set.
- Read path:
  - rd_en at cycle N samples bank_sel[rd_ch] as it stands before any same-cycle commit.
  - q, rd_wcnt and q_valid are presented at N+1.
  - With rd_en=0, q_valid=0 and q holds its value.
  - Reads at addresses >= wcnt return unspecified stale data; no error is flagged.
- Collisions:
  - A commit on channel X and a read of X in the same cycle: the read returns the old bank; reads from N+1 on see the new bank.
  - Reads never observe the open (inactive) bank.
- msg_new:
  - rd_ack clears msg_new[rd_ch].
  - Commit and rd_ack on the same channel in the same cycle leave the flag set.
- Async reset mid-message: the open message is lost. After release the committed view is bank 0 with wcnt=0, and old RAM data is not guaranteed meaningful.

Optional Feature:
- Macro MKIO_MSG_BUF_PARITY_EN.
- When defined:
  - Each RAM word stores an extra odd-parity bit computed from wr_data.
  - The read side recomputes parity and drives output rd_perr (1 bit, registered with q, reset 0) high with q_valid when the check fails.
  - A test-only input par_inj inverts the stored parity bit on writes.
- When undefined: no extra RAM bit; no rd_perr or par_inj ports.

Test Plan:
- Reset, then read channel 0 address 0 -> q_valid=1 at the next cycle, rd_wcnt=0, msg_new=0000.
- Start channel 2, write 0x1111..0x1113, commit -> msg_new=0100; reads of ch2 addresses 0..2 return 0x1111..0x1113 with rd_wcnt=3; rd_ack with rd_ch=2 -> msg_new=0000.
- Second message on ch2 (0xAAAA) with a ch2 read of address 0 in the commit cycle -> that read returns 0x1111; the next read returns 0xAAAA with rd_wcnt=1.
- Start ch1, write 33 words, commit -> wr_ovf=1; ch1 wcnt and bank unchanged, msg_new[1]=0; the next wr_start clears wr_ovf.
- Start ch3, write 2 words, assert wr_abort and wr_commit together -> abort wins, msg_new[3]=0. wr_start then immediately wr_commit -> wcnt=0, msg_new[3]=1.
- Parity build: write 0x0001 with par_inj=1, commit, read -> rd_perr=1 with q=0x0001; a clean word -> rd_perr=0.

Source files
------------

// File: rtl/mkio_msg_buf.sv
// Double-buffered per-channel MKIO message RAM: writer fills the inactive bank, commit flips it atomically (parity option: MKIO_MSG_BUF_PARITY_EN).
// Read latency 1 cycle (q/rd_wcnt/q_valid registered); no backpressure, overflowing words are dropped and flagged in wr_ovf.
module mkio_msg_buf #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5,
  parameter int CH_WIDTH   = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [CH_WIDTH-1:0]     wr_ch,
  input  logic                    wr_start,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    wr_commit,
  input  logic                    wr_abort,
  output logic                    wr_busy,
  output logic                    wr_ovf,
`ifdef MKIO_MSG_BUF_PARITY_EN
  input  logic                    par_inj,
  output logic                    rd_perr,
`endif
  input  logic [CH_WIDTH-1:0]     rd_ch,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  input  logic                    rd_en,
  input  logic                    rd_ack,
  output logic [DATA_WIDTH-1:0]   q,
  output logic                    q_valid,
  output logic [ADDR_WIDTH:0]     rd_wcnt,
  output logic [(1<<CH_WIDTH)-1:0] msg_new
);

  localparam int CHANNELS = 1 << CH_WIDTH;
  localparam int RAM_AW   = CH_WIDTH + 1 + ADDR_WIDTH;
  localparam int RAM_WORDS = 1 << RAM_AW;
`ifdef MKIO_MSG_BUF_PARITY_EN
  localparam int RAM_DW = DATA_WIDTH + 1;
`else
  localparam int RAM_DW = DATA_WIDTH;
`endif

  typedef enum logic {IDLE, OPEN} state_t;

  state_t                  state_q, state_d;
  logic [CH_WIDTH-1:0]     ch_q, ch_d;
  logic [ADDR_WIDTH:0]     ptr_q, ptr_d;
  logic                    ovf_q, ovf_d;
  logic                    we, commit;

  logic [CHANNELS-1:0]     bank_sel;
  logic [ADDR_WIDTH:0]     wcnt [CHANNELS];
  logic [CHANNELS-1:0]     msg_new_d;

  logic [RAM_DW-1:0]       ram [RAM_WORDS];
  logic [RAM_AW-1:0]       waddr, raddr;
  logic [RAM_DW-1:0]       wdat, rdat;

  // A start always wins: it discards whatever is open and ignores same-cycle wr_en.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    ovf_d   = ovf_q;
    we      = 1'b0;
    commit  = 1'b0;
    if (wr_start) begin
      state_d = OPEN;
      ch_d    = wr_ch;
      ptr_d   = '0;
      ovf_d   = 1'b0;
    end else if (state_q == OPEN) begin
      if (wr_en) begin
        if (ptr_q[ADDR_WIDTH]) begin
          ovf_d = 1'b1;
        end else begin
          we    = 1'b1;
          ptr_d = ptr_q + 1'b1;
        end
      end
      if (wr_abort) begin
        state_d = IDLE;
      end else if (wr_commit) begin
        state_d = IDLE;
        commit  = ~ovf_d;
      end
    end
  end

  always_comb begin
    msg_new_d = msg_new;
    if (rd_ack) msg_new_d[rd_ch] = 1'b0;
    if (commit) msg_new_d[ch_q]  = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      ptr_q    <= '0;
      ovf_q    <= 1'b0;
      bank_sel <= '0;
      msg_new  <= '0;
      for (int i = 0; i < CHANNELS; i++) wcnt[i] <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
      ovf_q   <= ovf_d;
      msg_new <= msg_new_d;
      if (commit) begin
        bank_sel[ch_q] <= ~bank_sel[ch_q];
        wcnt[ch_q]     <= ptr_d;
      end
    end
  end

  assign wr_busy = (state_q == OPEN);
  assign wr_ovf  = ovf_q;

  // Writer targets the inactive bank, reader the committed one, so the ports never collide.
  assign waddr = {ch_q, ~bank_sel[ch_q], ptr_q[ADDR_WIDTH-1:0]};
  assign raddr = {rd_ch, bank_sel[rd_ch], rd_addr};
`ifdef MKIO_MSG_BUF_PARITY_EN
  assign wdat = {(~^wr_data) ^ par_inj, wr_data};
`else
  assign wdat = wr_data;
`endif

  always_ff @(posedge clk) begin
    if (we) ram[waddr] <= wdat;
  end

  assign rdat = ram[raddr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q       <= '0;
      q_valid <= 1'b0;
      rd_wcnt <= '0;
`ifdef MKIO_MSG_BUF_PARITY_EN
      rd_perr <= 1'b0;
`endif
    end else begin
      q_valid <= rd_en;
      if (rd_en) begin
        q       <= rdat[DATA_WIDTH-1:0];
        rd_wcnt <= wcnt[rd_ch];
      end
`ifdef MKIO_MSG_BUF_PARITY_EN
      rd_perr <= rd_en & ~(^rdat);
`endif
    end
  end

endmodule

// File: tb/tb_mkio_msg_buf.sv
// Directed bench for mkio_msg_buf; parity checks are built when MKIO_MSG_BUF_PARITY_EN is defined.
module tb_mkio_msg_buf;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  wr_ch = '0;
  logic        wr_start = 1'b0;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = '0;
  logic        wr_commit = 1'b0;
  logic        wr_abort = 1'b0;
  logic        wr_busy, wr_ovf;
  logic [1:0]  rd_ch = '0;
  logic [4:0]  rd_addr = '0;
  logic        rd_en = 1'b0;
  logic        rd_ack = 1'b0;
  logic [15:0] q;
  logic        q_valid;
  logic [5:0]  rd_wcnt;
  logic [3:0]  msg_new;
`ifdef MKIO_MSG_BUF_PARITY_EN
  logic        par_inj = 1'b0;
  logic        rd_perr;
`endif

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  mkio_msg_buf dut (
    .clk(clk), .reset_n(reset_n),
    .wr_ch(wr_ch), .wr_start(wr_start), .wr_en(wr_en), .wr_data(wr_data),
    .wr_commit(wr_commit), .wr_abort(wr_abort), .wr_busy(wr_busy), .wr_ovf(wr_ovf),
`ifdef MKIO_MSG_BUF_PARITY_EN
    .par_inj(par_inj), .rd_perr(rd_perr),
`endif
    .rd_ch(rd_ch), .rd_addr(rd_addr), .rd_en(rd_en), .rd_ack(rd_ack),
    .q(q), .q_valid(q_valid), .rd_wcnt(rd_wcnt), .msg_new(msg_new)
  );

  // Stimulus drivers: inputs change just after a falling edge, outputs are sampled on the next one.
  task automatic start(input logic [1:0] ch);
    wr_ch = ch; wr_start = 1'b1;
    @(negedge clk);
    wr_start = 1'b0;
  endtask

  task automatic wr(input logic [15:0] d);
    wr_data = d; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic commit();
    wr_commit = 1'b1;
    @(negedge clk);
    wr_commit = 1'b0;
  endtask

  task automatic ack(input logic [1:0] ch);
    rd_ch = ch; rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
  endtask

  task automatic rd(input logic [1:0] ch, input logic [4:0] a,
                    output logic [15:0] dq, output logic [5:0] dw, output logic dv);
    rd_ch = ch; rd_addr = a; rd_en = 1'b1;
    @(negedge clk);
    dq = q; dw = rd_wcnt; dv = q_valid;
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] dq; logic [5:0] dw; logic dv;
    repeat (2) @(negedge clk);
    checks++; if (wr_busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", wr_busy); else passes++;
    checks++; if (wr_ovf !== 1'b0) $display("FAIL rst_ovf got %b exp 0", wr_ovf); else passes++;
    checks++; if (q !== 16'h0) $display("FAIL rst_q got %h exp 0000", q); else passes++;
    checks++; if (q_valid !== 1'b0) $display("FAIL rst_qv got %b exp 0", q_valid); else passes++;
    checks++; if (rd_wcnt !== 6'd0) $display("FAIL rst_wcnt got %0d exp 0", rd_wcnt); else passes++;
    checks++; if (msg_new !== 4'b0000) $display("FAIL rst_new got %b exp 0000", msg_new); else passes++;
`ifdef MKIO_MSG_BUF_PARITY_EN
    checks++; if (rd_perr !== 1'b0) $display("FAIL rst_perr got %b exp 0", rd_perr); else passes++;
`endif
    reset_n = 1'b1;
    @(negedge clk);
    rd(2'd0, 5'd0, dq, dw, dv);
    checks++; if (dv !== 1'b1) $display("FAIL rd0_qv got %b exp 1", dv); else passes++;
    checks++; if (dw !== 6'd0) $display("FAIL rd0_wcnt got %0d exp 0", dw); else passes++;
    checks++; if (msg_new !== 4'b0000) $display("FAIL rd0_new got %b exp 0000", msg_new); else passes++;
    @(negedge clk);
    checks++; if (q_valid !== 1'b0) $display("FAIL rd0_qv_drop got %b exp 0", q_valid); else passes++;
  endtask

  task automatic test_commit();
    logic [15:0] dq; logic [5:0] dw; logic dv;
    start(2'd2);
    checks++; if (wr_busy !== 1'b1) $display("FAIL c_busy got %b exp 1", wr_busy); else passes++;
    wr(16'h1111); wr(16'h1112); wr(16'h1113);
    commit();
    checks++; if (wr_busy !== 1'b0) $display("FAIL c_idle got %b exp 0", wr_busy); else passes++;
    checks++; if (msg_new !== 4'b0100) $display("FAIL c_new got %b exp 0100", msg_new); else passes++;
    for (int i = 0; i < 3; i++) begin
      rd(2'd2, 5'(i), dq, dw, dv);
      checks++; if (dq !== 16'h1111 + 16'(i)) $display("FAIL c_q%0d got %h exp %h", i, dq, 16'h1111 + 16'(i)); else passes++;
      checks++; if (dw !== 6'd3) $display("FAIL c_wcnt%0d got %0d exp 3", i, dw); else passes++;
    end
    @(negedge clk);
    checks++; if (q !== 16'h1113 || q_valid !== 1'b0) $display("FAIL c_hold got q=%h qv=%b exp 1113/0", q, q_valid); else passes++;
    ack(2'd2);
    checks++; if (msg_new !== 4'b0000) $display("FAIL c_ack got %b exp 0000", msg_new); else passes++;
  endtask

  task automatic test_collision();
    logic [15:0] dq; logic [5:0] dw; logic dv;
    start(2'd2);
    wr(16'hAAAA);
    wr_commit = 1'b1; rd_ack = 1'b1; rd_ch = 2'd2; rd_addr = 5'd0; rd_en = 1'b1;
    @(negedge clk);
    wr_commit = 1'b0; rd_ack = 1'b0; rd_en = 1'b0;
    checks++; if (q !== 16'h1111) $display("FAIL col_q got %h exp 1111", q); else passes++;
    checks++; if (rd_wcnt !== 6'd3) $display("FAIL col_wcnt got %0d exp 3", rd_wcnt); else passes++;
    checks++; if (msg_new !== 4'b0100) $display("FAIL col_new got %b exp 0100", msg_new); else passes++;
    rd(2'd2, 5'd0, dq, dw, dv);
    checks++; if (dq !== 16'hAAAA) $display("FAIL col_q2 got %h exp aaaa", dq); else passes++;
    checks++; if (dw !== 6'd1) $display("FAIL col_wcnt2 got %0d exp 1", dw); else passes++;
    ack(2'd2);
  endtask

  task automatic test_overflow();
    logic [15:0] dq; logic [5:0] dw; logic dv;
    start(2'd1); wr(16'h5A5A); commit(); ack(2'd1);
    start(2'd1);
    for (int i = 0; i < 32; i++) wr(16'(i));
    checks++; if (wr_ovf !== 1'b0) $display("FAIL ovf_32 got %b exp 0", wr_ovf); else passes++;
    wr(16'hFFFF);
    checks++; if (wr_ovf !== 1'b1) $display("FAIL ovf_33 got %b exp 1", wr_ovf); else passes++;
    commit();
    checks++; if (wr_ovf !== 1'b1 || wr_busy !== 1'b0) $display("FAIL ovf_commit got ovf=%b busy=%b exp 1/0", wr_ovf, wr_busy); else passes++;
    checks++; if (msg_new !== 4'b0000) $display("FAIL ovf_new got %b exp 0000", msg_new); else passes++;
    rd(2'd1, 5'd0, dq, dw, dv);
    checks++; if (dq !== 16'h5A5A) $display("FAIL ovf_q got %h exp 5a5a", dq); else passes++;
    checks++; if (dw !== 6'd1) $display("FAIL ovf_wcnt got %0d exp 1", dw); else passes++;
    start(2'd0);
    checks++; if (wr_ovf !== 1'b0 || wr_busy !== 1'b1) $display("FAIL ovf_clr got ovf=%b busy=%b exp 0/1", wr_ovf, wr_busy); else passes++;
    wr_abort = 1'b1; @(negedge clk); wr_abort = 1'b0;
  endtask

  task automatic test_abort();
    logic [15:0] dq; logic [5:0] dw; logic dv;
    start(2'd3); wr(16'h0001); wr(16'h0002);
    wr_abort = 1'b1; wr_commit = 1'b1;
    @(negedge clk);
    wr_abort = 1'b0; wr_commit = 1'b0;
    checks++; if (msg_new !== 4'b0000 || wr_busy !== 1'b0) $display("FAIL ab_new got new=%b busy=%b exp 0000/0", msg_new, wr_busy); else passes++;
    rd(2'd3, 5'd0, dq, dw, dv);
    checks++; if (dw !== 6'd0) $display("FAIL ab_wcnt got %0d exp 0", dw); else passes++;
    start(2'd3); commit();
    checks++; if (msg_new !== 4'b1000) $display("FAIL zl_new got %b exp 1000", msg_new); else passes++;
    rd(2'd3, 5'd0, dq, dw, dv);
    checks++; if (dw !== 6'd0) $display("FAIL zl_wcnt got %0d exp 0", dw); else passes++;
    ack(2'd3);
  endtask

  task automatic test_restart();
    logic [15:0] dq; logic [5:0] dw; logic dv;
    start(2'd0); wr(16'h1234);
    start(2'd3); wr(16'hBEEF); commit();
    checks++; if (msg_new !== 4'b1000) $display("FAIL rs_new got %b exp 1000", msg_new); else passes++;
    rd(2'd3, 5'd0, dq, dw, dv);
    checks++; if (dq !== 16'hBEEF || dw !== 6'd1) $display("FAIL rs_q got %h/%0d exp beef/1", dq, dw); else passes++;
    rd(2'd0, 5'd0, dq, dw, dv);
    checks++; if (dw !== 6'd0) $display("FAIL rs_ch0 got %0d exp 0", dw); else passes++;
    ack(2'd3);
  endtask

`ifdef MKIO_MSG_BUF_PARITY_EN
  task automatic test_parity();
    start(2'd0);
    par_inj = 1'b1; wr(16'h0001); par_inj = 1'b0;
    commit();
    rd_ch = 2'd0; rd_addr = 5'd0; rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    checks++; if (rd_perr !== 1'b1 || q !== 16'h0001) $display("FAIL par_bad got perr=%b q=%h exp 1/0001", rd_perr, q); else passes++;
    start(2'd0); wr(16'h0003); commit();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    checks++; if (rd_perr !== 1'b0 || q !== 16'h0003) $display("FAIL par_ok got perr=%b q=%h exp 0/0003", rd_perr, q); else passes++;
    ack(2'd0);
  endtask
`endif

  task automatic test_async_reset();
    logic [15:0] dq; logic [5:0] dw; logic dv;
    start(2'd1); wr(16'h4444); commit();
    checks++; if (msg_new !== 4'b0010) $display("FAIL ar_pre got %b exp 0010", msg_new); else passes++;
    start(2'd2); wr(16'h7777);
    #2 reset_n = 1'b0;
    #2;
    checks++; if (wr_busy !== 1'b0 || msg_new !== 4'b0000) $display("FAIL ar_state got busy=%b new=%b exp 0/0000", wr_busy, msg_new); else passes++;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    rd(2'd1, 5'd0, dq, dw, dv);
    checks++; if (dw !== 6'd0) $display("FAIL ar_wcnt1 got %0d exp 0", dw); else passes++;
    rd(2'd2, 5'd0, dq, dw, dv);
    checks++; if (dw !== 6'd0 || wr_busy !== 1'b0) $display("FAIL ar_wcnt2 got %0d/%b exp 0/0", dw, wr_busy); else passes++;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_commit();
    test_collision();
    test_overflow();
    test_abort();
    test_restart();
`ifdef MKIO_MSG_BUF_PARITY_EN
    test_parity();
`endif
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
